// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one main-memory port between two requesters
module mem_port_arbiter #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0,
   input  logic        req1,
   input  logic        write0,
   input  logic        write1,
   input  logic [31:0] addr0,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata0,
   input  logic [31:0] wdata1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        done0,
   output logic        done1,
   output logic        err0,
   output logic        err1,
   output logic [31:0] rdata0,
   output logic [31:0] rdata1,
   output logic        mem_req,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic [31:0] grant_count0,
   output logic [31:0] grant_count1
);

   typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

   localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT);

   state_t      state, state_nxt;
   logic        last;
   logic        owner;
   logic        wr_lat;
   logic [31:0] cnt;
   logic        pick;
   logic        complete;
   logic        abort;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // mem_ready only counts once mem_req is visible to the memory
   always_comb begin
      pick      = (req0 & req1) ? ~last : req1;
      complete  = (state == BUSY) && mem_req && mem_ready;
      abort     = (state == BUSY) && !complete && (cnt == TIMEOUT_W);
      state_nxt = state;
      case (state)
         IDLE:    if (req0 | req1) state_nxt = BUSY;
         BUSY:    if (complete | abort) state_nxt = RELEASE;
         RELEASE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last         <= 1'b1;
         owner        <= 1'b0;
         wr_lat       <= 1'b0;
         cnt          <= '0;
         gnt0         <= 1'b0;
         gnt1         <= 1'b0;
         done0        <= 1'b0;
         done1        <= 1'b0;
         err0         <= 1'b0;
         err1         <= 1'b0;
         rdata0       <= '0;
         rdata1       <= '0;
         mem_req      <= 1'b0;
         mem_write    <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         grant_count0 <= '0;
         grant_count1 <= '0;
      end else begin
         done0 <= 1'b0;
         done1 <= 1'b0;
         err0  <= 1'b0;
         err1  <= 1'b0;
         case (state)
            IDLE: begin
               if (req0 | req1) begin
                  owner     <= pick;
                  gnt0      <= ~pick;
                  gnt1      <= pick;
                  wr_lat    <= pick ? write1 : write0;
                  mem_addr  <= pick ? addr1 : addr0;
                  mem_wdata <= pick ? wdata1 : wdata0;
                  cnt       <= '0;
               end
            end
            BUSY: begin
               if (complete | abort) begin
                  mem_req   <= 1'b0;
                  mem_write <= 1'b0;
                  gnt0      <= 1'b0;
                  gnt1      <= 1'b0;
                  last      <= owner;
                  if (owner) begin
                     done1        <= 1'b1;
                     err1         <= abort;
                     grant_count1 <= grant_count1 + 32'd1;
                     if (!wr_lat) rdata1 <= complete ? mem_rdata : 32'hDEAD_BEEF;
                  end else begin
                     done0        <= 1'b1;
                     err0         <= abort;
                     grant_count0 <= grant_count0 + 32'd1;
                     if (!wr_lat) rdata0 <= complete ? mem_rdata : 32'hDEAD_BEEF;
                  end
               end else begin
                  mem_req   <= 1'b1;
                  mem_write <= wr_lat;
                  cnt       <= cnt + 32'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0, req1, write0, write1;
   logic [31:0] addr0, addr1, wdata0, wdata1;
   logic        gnt0, gnt1, done0, done1, err0, err1;
   logic [31:0] rdata0, rdata1;
   logic        mem_req, mem_write;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_ready;
   logic [31:0] grant_count0, grant_count1;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.TIMEOUT(4)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .write0(write0), .write1(write1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .err0(err0), .err1(err1), .rdata0(rdata0), .rdata1(rdata1),
      .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .grant_count0(grant_count0), .grant_count1(grant_count1)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k;
      logic seen;
      reset = 1'b1;
      {req0, req1, write0, write1, mem_ready} = '0;
      {addr0, addr1, wdata0, wdata1, mem_rdata} = '0;
      tick; tick;
      check("rst_ctrl", 32'({gnt0, gnt1, done0, done1, err0, err1, mem_req, mem_write}), 32'h0);
      check("rst_addr", mem_addr, 32'h0);
      check("rst_rdata0", rdata0, 32'h0);
      check("rst_cnt0", grant_count0, 32'h0);
      reset = 1'b0;
      tick;

      // single read from requester 0
      req0 = 1'b1; write0 = 1'b0; addr0 = 32'h100;
      tick;
      check("rd_gnt", 32'({gnt0, gnt1}), 32'h2);
      check("rd_memreq_early", 32'(mem_req), 32'h0);
      check("rd_addr", mem_addr, 32'h100);
      tick;
      check("rd_memreq", 32'({mem_req, mem_write}), 32'h2);
      tick; tick;
      mem_ready = 1'b1; mem_rdata = 32'hCAFE0001;
      tick;
      mem_ready = 1'b0; req0 = 1'b0;
      check("rd_done", 32'({done0, err0, done1}), 32'h4);
      check("rd_rdata", rdata0, 32'hCAFE0001);
      check("rd_cnt", grant_count0, 32'd1);
      check("rd_release", 32'({mem_req, gnt0}), 32'h0);
      tick;
      check("rd_pulse", 32'(done0), 32'h0);
      tick;

      // reset mid-transfer
      req1 = 1'b1; write1 = 1'b0; addr1 = 32'h200;
      tick; tick;
      check("mid_busy", 32'({mem_req, gnt1}), 32'h3);
      reset = 1'b1;
      #1;
      check("mid_async", 32'({mem_req, gnt0, gnt1}), 32'h0);
      check("mid_cnt0", grant_count0, 32'h0);
      req1 = 1'b0;
      tick;
      reset = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         mem_ready = 1'b1;
         tick;
         seen = seen | done0 | done1 | gnt0 | gnt1;
      end
      mem_ready = 1'b0;
      check("mid_no_done", 32'(seen), 32'h0);

      // tie after reset: requester 0 first, then 1
      req0 = 1'b1; req1 = 1'b1; addr0 = 32'h400; addr1 = 32'h500;
      tick;
      check("tie1_gnt", 32'({gnt0, gnt1}), 32'h2);
      check("tie1_addr", mem_addr, 32'h400);
      tick;
      mem_ready = 1'b1; mem_rdata = 32'hA0;
      tick;
      mem_ready = 1'b0; req0 = 1'b0;
      check("tie1_done", 32'({done0, done1}), 32'h2);
      tick;
      check("tie_release", 32'({gnt0, gnt1, mem_req}), 32'h0);
      tick;
      check("tie2_gnt", 32'({gnt0, gnt1}), 32'h1);
      check("tie2_addr", mem_addr, 32'h500);
      tick;
      mem_ready = 1'b1; mem_rdata = 32'hB1;
      tick;
      mem_ready = 1'b0; req1 = 1'b0;
      check("tie2_done", 32'({done0, done1}), 32'h1);
      check("tie2_rdata1", rdata1, 32'hB1);
      check("tie2_rdata0", rdata0, 32'hA0);
      tick; tick;

      // sustained contention: 0,1,0,1,0,1
      req0 = 1'b1; req1 = 1'b1;
      for (int i = 0; i < 6; i++) begin
         k = 0;
         do begin
            tick;
            k++;
         end while (!(gnt0 | gnt1) && k < 8);
         check("cont_gnt", 32'({gnt0, gnt1}), (i % 2 == 1) ? 32'h1 : 32'h2);
         if (i > 0) check("cont_spacing", 32'(k), 32'd2);
         tick;
         mem_ready = 1'b1; mem_rdata = 32'(i);
         tick;
         mem_ready = 1'b0;
         check("cont_done", 32'({done0, done1}), (i % 2 == 1) ? 32'h1 : 32'h2);
      end
      req0 = 1'b0; req1 = 1'b0;
      tick; tick;
      check("cont_cnt0", grant_count0, 32'd4);
      check("cont_cnt1", grant_count1, 32'd4);

      // timeout on a read from requester 1
      req1 = 1'b1; write1 = 1'b0; addr1 = 32'h600;
      tick;
      tick;
      check("to_memreq", 32'(mem_req), 32'h1);
      tick; tick; tick;
      check("to_not_early", 32'({done1, mem_req}), 32'h1);
      tick;
      req1 = 1'b0;
      check("to_done", 32'({done1, err1}), 32'h3);
      check("to_rdata", rdata1, 32'hDEADBEEF);
      check("to_memreq_low", 32'(mem_req), 32'h0);
      tick;
      check("to_pulse", 32'({done1, err1}), 32'h0);
      check("to_cnt1", grant_count1, 32'd5);
      tick;

      // write isolation
      req1 = 1'b1; write1 = 1'b1; addr1 = 32'h700; wdata1 = 32'h12345678;
      tick;
      addr1 = 32'h999; wdata1 = 32'h0; write1 = 1'b0;
      tick;
      check("wr_strobe", 32'({mem_req, mem_write}), 32'h3);
      check("wr_addr", mem_addr, 32'h700);
      check("wr_wdata", mem_wdata, 32'h12345678);
      mem_ready = 1'b1; mem_rdata = 32'h55555555;
      tick;
      mem_ready = 1'b0; req1 = 1'b0;
      check("wr_done", 32'({done1, err1, mem_write}), 32'h4);
      check("wr_rdata1", rdata1, 32'hDEADBEEF);
      tick; tick;

      // mem_ready outside BUSY has no effect
      mem_ready = 1'b1;
      tick; tick;
      mem_ready = 1'b0;
      check("idle_ready", 32'({done0, done1, gnt0, gnt1}), 32'h0);
      check("idle_cnt1", grant_count1, 32'd6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
